// File: rtl/logic_pipe.sv
// Elastic pipelined bitwise logic unit: eight selectable operations on two
// operands, STAGES register stages with valid/ready flow control, zero flag.
module logic_pipe #(
  parameter int BITS   = 8,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic [2:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out,
  output logic            out_zero
);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_v;
  logic [BITS:0]     data_q [STAGES];
  logic [BITS:0]     data_d [STAGES];
  logic [BITS:0]     src_d  [STAGES];
  logic [BITS-1:0]   result;

  always_comb begin
    result = '0;
    case (op)
      3'd0: result = ~(a & b);
      3'd1: result = a & b;
      3'd2: result = a | b;
      3'd3: result = ~(a | b);
      3'd4: result = a ^ b;
      3'd5: result = ~(a ^ b);
      3'd6: result = a & ~b;
      3'd7: result = ~a;
      default: result = '0;
    endcase
  end

  assign in_ready = load[0] & reset;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // Stage gi can load unless it and every stage after it are full and the
      // consumer is stalled; the mask ignores stages upstream of gi.
      localparam logic [STAGES-1:0] LOW_MASK = STAGES'((64'd1 << gi) - 64'd1);
      assign load[gi] = ~(&(v_q | LOW_MASK)) | out_ready;

      if (gi == 0) begin : g_head
        assign src_v[gi] = in_valid & in_ready;
        assign src_d[gi] = {(result == '0), result};
      end else begin : g_body
        assign src_v[gi] = v_q[gi-1];
        assign src_d[gi] = data_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    v_d = v_q;
    for (int k = 0; k < STAGES; k++) begin
      data_d[k] = data_q[k];
      if (load[k]) begin
        v_d[k] = src_v[k];
        if (src_v[k]) data_d[k] = src_d[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out       = data_q[STAGES-1][BITS-1:0];
  assign out_zero  = data_q[STAGES-1][BITS];

endmodule
